// File: rtl/chunked_mag_comp.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB chunk first.
// Macro COMP_EARLY_EXIT_EN: exit on first differing chunk; otherwise constant NCHUNK-cycle walk.
module chunked_mag_comp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       c
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_params
      $error("chunked_mag_comp: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             smode_r;
  logic [IDXW-1:0]  idx_r;
  logic [2:0]       c_r;
  logic             out_valid_r;
`ifndef COMP_EARLY_EXIT_EN
  logic             decided_r;
  logic [2:0]       pend_r;
`endif

  logic [CHUNK-1:0] flip_s;
  logic [CHUNK-1:0] chunk_a_s;
  logic [CHUNK-1:0] chunk_b_s;
  logic [2:0]       cmp_s;

  // Current chunk compare; flipping the sign bit maps two's-complement order onto unsigned order
  always_comb begin
    flip_s            = '0;
    flip_s[CHUNK-1]   = smode_r && (idx_r == IDX_LAST);
    chunk_a_s         = a_r[idx_r*CHUNK +: CHUNK] ^ flip_s;
    chunk_b_s         = b_r[idx_r*CHUNK +: CHUNK] ^ flip_s;
    if (chunk_a_s > chunk_b_s) begin
      cmp_s = 3'b100;
    end else if (chunk_a_s < chunk_b_s) begin
      cmp_s = 3'b001;
    end else begin
      cmp_s = 3'b010;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign c         = c_r;

  // Control FSM with registered result and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      smode_r     <= 1'b0;
      idx_r       <= '0;
      c_r         <= 3'b000;
      out_valid_r <= 1'b0;
`ifndef COMP_EARLY_EXIT_EN
      decided_r   <= 1'b0;
      pend_r      <= 3'b000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (in_valid) begin
            a_r       <= a;
            b_r       <= b;
            smode_r   <= signed_mode;
            idx_r     <= IDX_LAST;
`ifndef COMP_EARLY_EXIT_EN
            decided_r <= 1'b0;
            pend_r    <= 3'b000;
`endif
            state_r   <= CMP;
          end else begin
            state_r   <= IDLE;
          end
        end
        CMP: begin
`ifdef COMP_EARLY_EXIT_EN
          if (cmp_s != 3'b010 || idx_r == '0) begin
            c_r         <= cmp_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r       <= idx_r - IDXW'(1);
          end
`else
          // Most significant difference wins and is held until the walk ends
          if (!decided_r && cmp_s != 3'b010) begin
            decided_r <= 1'b1;
            pend_r    <= cmp_s;
          end else begin
            decided_r <= decided_r;
          end
          if (idx_r == '0) begin
            c_r         <= decided_r ? pend_r : cmp_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r       <= idx_r - IDXW'(1);
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_mag_comp.sv
// Directed self-checking bench for chunked_mag_comp (WIDTH=32, CHUNK=8), either build of COMP_EARLY_EXIT_EN.
module tb_chunked_mag_comp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  c;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef COMP_EARLY_EXIT_EN
  localparam int LAT_TOP = 1;
`else
  localparam int LAT_TOP = 4;
`endif

  chunked_mag_comp #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .c(c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] av;
    logic [31:0] bv;
    logic        sm;
    logic [2:0]  exp_c;
    logic [7:0]  exp_lat;
  } vec_t;

  // Presents operands for one accept edge; returns at accept edge + 1
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sm);
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    #12;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_vec++; if (c !== 3'b000) begin n_miss++; $display("FAIL reset_c got=%b want=000", c); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    vec_t vecs[8];
    int   lat;
    vecs[0] = '{32'h8000_0000, 32'h0000_0008, 1'b0, 3'b100, 8'(LAT_TOP)};
    vecs[1] = '{32'h8000_0000, 32'h0000_0008, 1'b1, 3'b001, 8'(LAT_TOP)};
    vecs[2] = '{32'h0000_001C, 32'h0000_0018, 1'b0, 3'b100, 8'd4};
    vecs[3] = '{32'h0000_0018, 32'h0000_001C, 1'b0, 3'b001, 8'd4};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b010, 8'd4};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b010, 8'd4};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 3'b010, 8'd4};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 3'b010, 8'd4};
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].av, vecs[i].bv, vecs[i].sm);
      wait_result(lat);
      n_vec++; if (lat != int'(vecs[i].exp_lat)) begin n_miss++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, vecs[i].exp_lat); end
      n_vec++; if (c !== vecs[i].exp_c) begin n_miss++; $display("FAIL vec%0d_c got=%b want=%b", i, c, vecs[i].exp_c); end
      release_result;
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL vec%0d_out_valid_drop got=%b want=0", i, out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL vec%0d_in_ready_back got=%b want=1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(32'h0000_0001, 32'h0000_0002, 1'b0);
    wait_result(lat);
    n_vec++; if (lat != 4) begin n_miss++; $display("FAIL bp_latency got=%0d want=4", lat); end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        a = 32'h0000_0005; b = 32'h0000_0003; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || c !== 3'b001 || in_ready !== 1'b0) begin
        n_miss++;
        $display("FAIL bp_hold%0d got ov=%b c=%b ir=%b want ov=1 c=001 ir=0", k, out_valid, c, in_ready);
      end
    end
    in_valid = 1'b0;
    release_result;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    repeat (6) begin @(posedge clk); #1; end
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_pulse_ignored got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    start_op(32'h0000_001C, 32'h0000_0018, 1'b0);
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_mid_busy got ir=%b ov=%b want ir=0 ov=0", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    n_vec++; if (c !== 3'b000) begin n_miss++; $display("FAIL rst_mid_c got=%b want=000", c); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(32'h8000_0000, 32'h0000_0008, 1'b0);
    wait_result(lat);
    n_vec++; if (lat != LAT_TOP) begin n_miss++; $display("FAIL rst_after_latency got=%0d want=%0d", lat, LAT_TOP); end
    n_vec++; if (c !== 3'b100) begin n_miss++; $display("FAIL rst_after_c got=%b want=100", c); end
    release_result;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/chunked_mag_comp.md
Name: chunked_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator; generalises the 8-bit combinational comparator to WIDTH-bit operands.
- Compares CHUNK bits per cycle, MSB chunk first, in signed or unsigned mode.
- Valid/ready handshakes on both sides; sits between an operand-producing datapath and control logic that consumes the {gt, eq, lt} result.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK; NCHUNK >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- c  out  3  one-hot result: c[2] = A>B, c[1] = A==B, c[0] = A<B.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, out_valid=0, c=3'b000, chunk index=0, operand registers=0.
- in_ready is combinational, =1 only in IDLE, so it reads 1 during and right after reset.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - On in_valid && in_ready, latch a, b, signed_mode.
  - Set idx = NCHUNK-1 and go to CMP.
  - in_valid while not in IDLE is ignored; no operand is lost because in_ready=0.
- CMP: each cycle compare chunk idx of A vs B as unsigned CHUNK-bit values.
  - Signed mode, top chunk only: invert bit WIDTH-1 of both operands before compare. This maps two's-complement order onto unsigned order.
  - Chunks differ: load c with 3'b100 or 3'b001 and go to DONE.
  - Chunks equal and idx==0: load c=3'b010 and go to DONE.
  - Chunks equal and idx>0: idx <= idx-1 and stay in CMP.
- DONE:
  - out_valid=1; c stable until out_ready.
  - On out_valid && out_ready, go to IDLE and deassert out_valid next cycle.
  - c keeps the last result after the handshake; out_valid alone qualifies it.
- Latency: acceptance edge to out_valid high = k clock edges, where k = chunks examined (1..NCHUNK).
- Minimum throughput: one compare per k+2 cycles (no accept/complete overlap).
- c is always one-hot whenever out_valid=1.
- NCHUNK==1 degenerates to 1-cycle latency; signed inversion still applies to the single chunk.
- Reset asserted in any state: immediate return to reset values; the in-flight compare is discarded with no partial result.
- WIDTH % CHUNK != 0: elaboration-time error.

Optional Feature:
- Macro: COMP_EARLY_EXIT_EN.
- Defined: CMP exits on the first differing chunk, as described above; latency is data-dependent, 1..NCHUNK.
- Undefined: constant-time operation.
  - CMP always walks all NCHUNK chunks.
  - The first difference found (most significant) is captured in a sticky decided flag and held.
  - Transition to DONE only after idx==0; latency is always NCHUNK.
  - Results are identical to the defined case.

Test Plan (WIDTH=32, CHUNK=8):
1. Unsigned MSB-chunk difference: a=32'h8000_0000, b=32'h0000_0008, signed_mode=0 -> c=3'b100; out_valid 1 edge after accept with COMP_EARLY_EXIT_EN, 4 edges without.
2. Signed mode, same operands, signed_mode=1 -> c=3'b001 (A negative); same latencies as case 1.
3. Low-chunk difference: a=32'h0000_001C, b=32'h0000_0018 -> c=3'b100 after 4 edges in both builds. Then swap a and b -> c=3'b001 after 4 edges.
4. Equality: a=b=32'hFFFF_FFFF, each mode -> c=3'b010 after 4 edges. a=b=0 -> c=3'b010.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and c constant, in_ready=0.
   - A new in_valid pulse during those cycles is not accepted.
   - out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
6. Reset mid-operation: assert rst_n=0 asynchronously during CMP (case 3, idx=2) -> out_valid=0, c=3'b000, in_ready=1 immediately. Release, then issue case 1 -> correct result with normal latency.
